// File: rtl/cdb_arb_if.sv
// cdb_arb_if: bundles the FU hand-over bus, the ROB branch-resolution
// inputs and the registered CDB broadcast of the completion arbiter.
//   fu_vld_i / fu_dest_tag_i / fu_rob_idx_i / fu_br_mask_i : per-FU result
//   fu_rdy_o                                               : per-FU accept
//   rob_br_pred_correct_i / rob_br_recovery_i / rob_br_tag_fix_i : branch
//   cdb_vld_o / cdb_tag_o / cdb_rob_idx_o / cdb_br_mask_o  : broadcast
// Modports: slave = arbiter side, master = FU/ROB/consumer side.
interface cdb_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 4
);
  logic [NUM_REQ-1:0]                fu_vld_i;
  logic [NUM_REQ-1:0][PRF_IDX_W-1:0] fu_dest_tag_i;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] fu_rob_idx_i;
  logic [NUM_REQ-1:0][BR_MASK_W-1:0] fu_br_mask_i;
  logic [NUM_REQ-1:0]                fu_rdy_o;
  logic                              rob_br_pred_correct_i;
  logic                              rob_br_recovery_i;
  logic [BR_MASK_W-1:0]              rob_br_tag_fix_i;
  logic                              cdb_vld_o;
  logic [PRF_IDX_W-1:0]              cdb_tag_o;
  logic [ROB_IDX_W-1:0]              cdb_rob_idx_o;
  logic [BR_MASK_W-1:0]              cdb_br_mask_o;

  modport slave (
    input  fu_vld_i, fu_dest_tag_i, fu_rob_idx_i, fu_br_mask_i,
           rob_br_pred_correct_i, rob_br_recovery_i, rob_br_tag_fix_i,
    output fu_rdy_o, cdb_vld_o, cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o
  );

  modport master (
    output fu_vld_i, fu_dest_tag_i, fu_rob_idx_i, fu_br_mask_i,
           rob_br_pred_correct_i, rob_br_recovery_i, rob_br_tag_fix_i,
    input  fu_rdy_o, cdb_vld_o, cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o
  );
endinterface

// File: rtl/cdb_arb.sv
// cdb_arb: completion-side CDB scheduler. Each FU owns a 1-entry holding
// buffer; a round-robin arbiter picks one buffered result per cycle and
// drives the registered CDB broadcast. Buffered results are squashed on a
// mispredict and have their branch bit cleared on a correct prediction.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   bus    : cdb_arb_if.slave (FU hand-over, branch resolution, CDB out)
//   arb_conflict_cnt_o : [31:0] saturating count of cycles with >=2
//                        requesters (only with CDB_ARB_STAT_EN defined)
// Optional feature macro: CDB_ARB_STAT_EN.

// One FU holding buffer.
module cdb_arb_buf #(
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [PRF_IDX_W-1:0] in_tag,
  input  logic [ROB_IDX_W-1:0] in_rob,
  input  logic [BR_MASK_W-1:0] in_mask,
  input  logic                 br_recovery,
  input  logic                 br_correct,
  input  logic [BR_MASK_W-1:0] br_tag_fix,
  input  logic                 gnt,
  output logic                 req,
  output logic                 rdy,
  output logic [PRF_IDX_W-1:0] tag,
  output logic [ROB_IDX_W-1:0] rob,
  output logic [BR_MASK_W-1:0] mask
);
  logic                 vld_q, vld_d;
  logic [PRF_IDX_W-1:0] tag_q, tag_d;
  logic [ROB_IDX_W-1:0] rob_q, rob_d;
  logic [BR_MASK_W-1:0] mask_q, mask_d;
  logic [BR_MASK_W-1:0] keep_mask;
  logic                 squash, in_squash, load;

  always_comb begin
    // Recovery wins over a simultaneous correct-prediction.
    keep_mask = (br_correct & ~br_recovery) ? ~br_tag_fix : '1;
    squash    = br_recovery & (|(mask_q & br_tag_fix));
    in_squash = br_recovery & (|(in_mask & br_tag_fix));
    req       = vld_q & ~squash;
    rdy       = ~vld_q | gnt;
    // A squashed incoming result is still accepted (rdy) and simply dropped.
    load      = in_vld & rdy & ~in_squash;
    tag       = tag_q;
    rob       = rob_q;
    mask      = mask_q & keep_mask;
    vld_d     = vld_q;
    tag_d     = tag_q;
    rob_d     = rob_q;
    mask_d    = mask_q & keep_mask;
    if (gnt | squash) vld_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      tag_d  = in_tag;
      rob_d  = in_rob;
      mask_d = in_mask & keep_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      rob_q  <= '0;
      mask_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      rob_q  <= rob_d;
      mask_q <= mask_d;
    end
  end
endmodule

module cdb_arb #(
  parameter int NUM_REQ   = 4,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  cdb_arb_if.slave   bus
`ifdef CDB_ARB_STAT_EN
  ,
  output logic [31:0] arb_conflict_cnt_o
`endif
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                req, gnt, rdy;
  logic [NUM_REQ-1:0][PRF_IDX_W-1:0] buf_tag;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] buf_rob;
  logic [NUM_REQ-1:0][BR_MASK_W-1:0] buf_mask;

  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [PTR_W-1:0]     gnt_idx, sel;
  logic                 found;
  int                   idx;
  logic                 cdb_vld_q, cdb_vld_d;
  logic [PRF_IDX_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [ROB_IDX_W-1:0] cdb_rob_q, cdb_rob_d;
  logic [BR_MASK_W-1:0] cdb_mask_q, cdb_mask_d;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
    cdb_arb_buf #(
      .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W), .BR_MASK_W(BR_MASK_W)
    ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .in_vld     (bus.fu_vld_i[g]),
      .in_tag     (bus.fu_dest_tag_i[g]),
      .in_rob     (bus.fu_rob_idx_i[g]),
      .in_mask    (bus.fu_br_mask_i[g]),
      .br_recovery(bus.rob_br_recovery_i),
      .br_correct (bus.rob_br_pred_correct_i),
      .br_tag_fix (bus.rob_br_tag_fix_i),
      .gnt        (gnt[g]),
      .req        (req[g]),
      .rdy        (rdy[g]),
      .tag        (buf_tag[g]),
      .rob        (buf_rob[g]),
      .mask       (buf_mask[g])
    );
  end

  // Round-robin: first requester at or after rr_q, cyclically upward.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    sel     = '0;
    idx     = 0;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        found   = 1'b1;
        gnt_idx = sel;
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d       = rr_q;
    cdb_vld_d  = found;
    cdb_tag_d  = cdb_tag_q;
    cdb_rob_d  = cdb_rob_q;
    cdb_mask_d = cdb_mask_q;
    if (found) begin
      rr_d       = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      cdb_tag_d  = buf_tag[gnt_idx];
      cdb_rob_d  = buf_rob[gnt_idx];
      cdb_mask_d = buf_mask[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q       <= '0;
      cdb_vld_q  <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_rob_q  <= '0;
      cdb_mask_q <= '0;
    end else begin
      rr_q       <= rr_d;
      cdb_vld_q  <= cdb_vld_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_rob_q  <= cdb_rob_d;
      cdb_mask_q <= cdb_mask_d;
    end
  end

  assign bus.fu_rdy_o      = rdy;
  assign bus.cdb_vld_o     = cdb_vld_q;
  assign bus.cdb_tag_o     = cdb_tag_q;
  assign bus.cdb_rob_idx_o = cdb_rob_q;
  assign bus.cdb_br_mask_o = cdb_mask_q;

`ifdef CDB_ARB_STAT_EN
  logic [31:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (($countones(req) >= 2) && (conflict_q != 32'hFFFF_FFFF))
      conflict_d = conflict_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conflict_q <= '0;
    else      conflict_q <= conflict_d;
  end

  assign arb_conflict_cnt_o = conflict_q;
`endif
endmodule

// File: tb/tb_cdb_arb.sv
// tb_cdb_arb: scoreboard bench for cdb_arb. A driver issues directed and
// random FU results / branch events at the falling edge and a reference
// model of the buffers pushes each expected broadcast (with the edge it
// must appear after) into a queue; a monitor pops and compares after every
// rising edge.
module tb_cdb_arb;
  localparam int N  = 4;
  localparam int TW = 6;
  localparam int RW = 5;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_arb_if #(.NUM_REQ(N), .PRF_IDX_W(TW), .ROB_IDX_W(RW), .BR_MASK_W(MW)) bus ();

`ifdef CDB_ARB_STAT_EN
  logic [31:0] conf_cnt;
`endif

  cdb_arb #(.NUM_REQ(N), .PRF_IDX_W(TW), .ROB_IDX_W(RW), .BR_MASK_W(MW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CDB_ARB_STAT_EN
    ,
    .arb_conflict_cnt_o(conf_cnt)
`endif
  );

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic [RW-1:0] rob;
    logic [MW-1:0] mask;
  } ent_t;

  typedef struct {
    int            exp_edge;
    logic [TW-1:0] tag;
    logic [RW-1:0] rob;
    logic [MW-1:0] mask;
  } exp_t;

  exp_t  sb_q[$];
  ent_t  m_buf[N];   // model of buffered results
  ent_t  pend[N];    // result each FU is currently offering
  int    m_rr;
  bit    br_rec, br_cor;
  logic [MW-1:0] br_fix;
  int    n_chk = 0;
  int    n_pass = 0;
  int    edge_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Monitor: after each rising edge either the queue head is due or the bus is idle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (rst) begin
        if (sb_q.size() > 0 && sb_q[0].exp_edge == edge_cnt) begin
          e = sb_q.pop_front();
          chk("cdb_vld", 32'(bus.cdb_vld_o), 32'd1);
          chk("cdb_tag", 32'(bus.cdb_tag_o), 32'(e.tag));
          chk("cdb_rob", 32'(bus.cdb_rob_idx_o), 32'(e.rob));
          chk("cdb_mask", 32'(bus.cdb_br_mask_o), 32'(e.mask));
        end else begin
          chk("cdb_idle", 32'(bus.cdb_vld_o), 32'd0);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_buf[i] = '0;
      pend[i]  = '0;
    end
    m_rr = 0;
    sb_q.delete();
  endtask

  // One clock: drive, check readiness, advance the model.
  task automatic cycle();
    bit            sq[N];
    bit            rq[N];
    logic [N-1:0]  exp_rdy;
    logic [MW-1:0] keep;
    int            g, j;
    exp_t          e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.fu_vld_i[i]      = pend[i].v;
      bus.fu_dest_tag_i[i] = pend[i].tag;
      bus.fu_rob_idx_i[i]  = pend[i].rob;
      bus.fu_br_mask_i[i]  = pend[i].mask;
    end
    bus.rob_br_recovery_i     = br_rec;
    bus.rob_br_pred_correct_i = br_cor;
    bus.rob_br_tag_fix_i      = br_fix;
    #1;
    keep = (br_cor && !br_rec) ? ~br_fix : {MW{1'b1}};
    for (int i = 0; i < N; i++) begin
      sq[i] = br_rec && ((m_buf[i].mask & br_fix) != 0);
      rq[i] = m_buf[i].v && !sq[i];
    end
    g = -1;
    for (int off = 0; off < N; off++) begin
      j = (m_rr + off) % N;
      if (g < 0 && rq[j]) g = j;
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = !m_buf[i].v || (g == i);
    chk("fu_rdy", 32'(bus.fu_rdy_o), 32'(exp_rdy));
    if (g >= 0) begin
      e.exp_edge = edge_cnt + 1;
      e.tag      = m_buf[g].tag;
      e.rob      = m_buf[g].rob;
      e.mask     = m_buf[g].mask & keep;
      sb_q.push_back(e);
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (sq[i] || g == i) m_buf[i].v = 1'b0;
      m_buf[i].mask = m_buf[i].mask & keep;
      if (pend[i].v && exp_rdy[i]) begin
        if (!(br_rec && ((pend[i].mask & br_fix) != 0)))
          m_buf[i] = '{1'b1, pend[i].tag, pend[i].rob, pend[i].mask & keep};
        pend[i].v = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    br_rec = 0; br_cor = 0; br_fix = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic offer(input int i, input int tag, input int rob, input logic [MW-1:0] mask);
    pend[i] = '{1'b1, TW'(tag), RW'(rob), mask};
  endtask

  // Asynchronous reset dropped between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    bus.fu_vld_i = '0;
    #1;
    chk("rst_cdb_vld", 32'(bus.cdb_vld_o), 32'd0);
    chk("rst_cdb_tag", 32'(bus.cdb_tag_o), 32'd0);
    chk("rst_cdb_rob", 32'(bus.cdb_rob_idx_o), 32'd0);
    chk("rst_cdb_mask", 32'(bus.cdb_br_mask_o), 32'd0);
    chk("rst_fu_rdy", 32'(bus.fu_rdy_o), 32'hF);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.fu_vld_i = '0;
    bus.fu_dest_tag_i = '0;
    bus.fu_rob_idx_i = '0;
    bus.fu_br_mask_i = '0;
    bus.rob_br_recovery_i = 1'b0;
    bus.rob_br_pred_correct_i = 1'b0;
    bus.rob_br_tag_fix_i = '0;
    br_rec = 0; br_cor = 0; br_fix = '0;
    model_clear();
    do_reset();

    // Four simultaneous results from rr_ptr=0: 10,11,12,13 in order.
    for (int i = 0; i < N; i++) offer(i, 10 + i, i, 4'b0000);
    idle(7);

    // Single ALU result, two-edge latency.
    offer(0, 12, 3, 4'b0000);
    idle(4);

    // Fairness: FU0 always busy, FU2 offers tag 40 once.
    offer(2, 40, 9, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      if (!pend[0].v) offer(0, 20 + k, k, 4'b0000);
      cycle();
    end
    idle(4);

    // Mispredict squash, including an incoming result that must be dropped.
    offer(1, 21, 1, 4'b0010);
    offer(3, 23, 3, 4'b0100);
    cycle();
    offer(0, 30, 0, 4'b0010);
    br_rec = 1; br_fix = 4'b0010;
    cycle();
    idle(4);

    // Correct prediction clears the resolved bit.
    offer(2, 33, 2, 4'b0110);
    cycle();
    br_cor = 1; br_fix = 4'b0100;
    cycle();
    idle(4);

    // Reset mid-stream with three buffers full and a live broadcast.
    for (int i = 0; i < N; i++) offer(i, 50 + i, i, 4'b0000);
    cycle();
    cycle();
    do_reset();
    offer(0, 60, 1, 4'b0000);
    offer(3, 61, 2, 4'b0000);
    idle(5);

    // Random traffic with branch events.
    for (int k = 0; k < 400; k++) begin
      int r;
      for (int i = 0; i < N; i++)
        if (!pend[i].v && ($urandom % 3 != 0))
          offer(i, int'($urandom % 64), int'($urandom % 32), MW'($urandom));
      r = int'($urandom % 10);
      br_rec = (r == 0);
      br_cor = (r == 1);
      br_fix = MW'(1 << ($urandom % MW));
      cycle();
    end
    for (int i = 0; i < N; i++) pend[i].v = 1'b0;
    idle(8);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cdb_arb.md
Name: cdb_arb

Overview:
- Completion-side scheduler that shares the single CDB among the functional units fed by the reservation station.
- Each FU hands over a finished result (dest tag, ROB index, branch mask) into a private 1-entry holding buffer.
- A round-robin arbiter picks one buffered result per cycle and drives the registered CDB broadcast consumed by the RS, map table and ROB.
- Buffered results are squashed or have their masks fixed on branch resolution.

Parameters:
- NUM_REQ, 4, number of FU requesters (0=ALU, 1=MULT, 2=LOAD, 3=BRANCH).
- PRF_IDX_W, 6, physical register tag width.
- ROB_IDX_W, 5, ROB index width.
- BR_MASK_W, 4, branch mask width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- fu_vld_i  in  NUM_REQ  per-FU result valid.
- fu_dest_tag_i  in  NUM_REQ*PRF_IDX_W  per-FU destination tag.
- fu_rob_idx_i  in  NUM_REQ*ROB_IDX_W  per-FU ROB index.
- fu_br_mask_i  in  NUM_REQ*BR_MASK_W  per-FU branch mask.
- fu_rdy_o  out  NUM_REQ  buffer can accept this cycle.
- rob_br_pred_correct_i  in  1  branch resolved correct.
- rob_br_recovery_i  in  1  branch mispredict recovery.
- rob_br_tag_fix_i  in  BR_MASK_W  one-hot tag of the resolved branch.
- cdb_vld_o  out  1  broadcast valid.
- cdb_tag_o  out  PRF_IDX_W  broadcast tag.
- cdb_rob_idx_o  out  ROB_IDX_W  broadcast ROB index.
- cdb_br_mask_o  out  BR_MASK_W  broadcast branch mask.

Behaviour:
- Reset (rst=0, async): all buffers empty, rr_ptr=0, cdb_vld_o=0, cdb_tag_o=0, cdb_rob_idx_o=0, cdb_br_mask_o=0. fu_rdy_o is all-ones while reset is held.
- Handshake: buffer i loads at an edge where fu_vld_i[i] & fu_rdy_o[i].
  - fu_rdy_o[i] = ~buf_vld[i] | gnt[i] (combinational).
  - A granted buffer accepts a new result in the same cycle (back-to-back throughput of 1/cycle per FU).
  - fu_vld_i with fu_rdy_o=0 is held by the FU and is not dropped.
- Arbitration (combinational):
  - Request vector = buf_vld after the squash below is applied.
  - Grant the first requester at or after rr_ptr, searching cyclically upward; at most one grant (one-hot).
  - On a grant to k, rr_ptr <= (k+1) mod NUM_REQ. With no grant, rr_ptr holds.
- CDB output: registered.
  - At each edge, cdb_* <= granted buffer contents and cdb_vld_o <= |gnt.
  - With no grant, cdb_vld_o <= 0 and the other cdb fields hold their value.
- Latency: result presented at edge k, uncontended, appears on cdb_vld_o in the cycle after edge k+1 (2 edges).
- Mispredict (rob_br_recovery_i=1):
  - Any buffer with (mask & rob_br_tag_fix_i)!=0 is treated as not requesting this cycle and is cleared at the edge.
  - An incoming result with a matching mask is not loaded. fu_rdy_o is still asserted for it, so the FU drops it.
  - The cdb register is not retro-cleared: a value already on the bus was granted before recovery.
  - Non-matching entries are unaffected.
- Correct prediction (rob_br_pred_correct_i=1): clear bit rob_br_tag_fix_i from every buffered mask and from any mask loaded or granted this cycle. cdb_br_mask_o carries the cleared mask.
- Simultaneous recovery and correct assertion does not occur; if it does, recovery takes precedence.
- All-full: 4 buffers valid gives 1 broadcast/cycle in rotating order. No FU waits more than NUM_REQ cycles for a grant (starvation-free).
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- CDB_ARB_STAT_EN defined:
  - Adds output arb_conflict_cnt_o [31:0].
  - Increments each cycle where 2 or more buffers request, saturating at 32'hFFFF_FFFF.
  - Reset to 0.
- CDB_ARB_STAT_EN undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Single ALU result: fu_vld_i=4'b0001, tag=6'd12, rob=5'd3, mask=4'b0000 at edge 1 -> cdb_vld_o=1, cdb_tag_o=12, cdb_rob_idx_o=3 after edge 2, then cdb_vld_o=0.
- Four simultaneous results, tags 10/11/12/13, rr_ptr=0 -> broadcasts 10, 11, 12, 13 on four consecutive cycles. fu_rdy_o[3]=1 only in the cycle it is granted.
- Fairness: FU0 continuously valid with fresh tags every cycle, FU2 valid once with tag 40 -> tag 40 broadcast within 2 cycles, then FU0 resumes. FU0 is never granted twice in a row while FU2 is pending.
- Mispredict squash: FU1 buffered with mask 4'b0010, FU3 buffered with mask 4'b0100. Assert recovery with tag_fix=4'b0010 -> FU1 entry never broadcast; FU3 broadcast next with mask 4'b0100.
- Correct prediction: buffered mask 4'b0110, rob_br_pred_correct_i with tag_fix=4'b0100 -> broadcast shows cdb_br_mask_o=4'b0010.
- Async reset mid-stream: drop rst low between edges with 3 buffers full -> cdb_vld_o=0 immediately. After release, no stale broadcasts and rr_ptr=0 (first grant goes to the lowest valid FU).
